// File: rtl/cluster_rate_monitor.sv
// Per-BX cluster-count monitor: flags over-threshold BXs and accumulates
// windowed sum / peak / overflow statistics into a valid/ready result slot.
module cluster_rate_monitor #(
    parameter int unsigned CNT_W = 11,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned SUM_W = 27
) (
    input  logic             clock4x,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             cnt_valid_i,
    input  logic [CNT_W-1:0] threshold_i,
    input  logic [WIN_W-1:0] window_bx_i,
    output logic             ovf_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [CNT_W-1:0] peak_o,
    output logic [WIN_W-1:0] ovf_bx_o,
    output logic [WIN_W-1:0] nbx_o,
    output logic             lost_o
);

    localparam int unsigned BXE_W = WIN_W + 1;
    localparam int unsigned SXE_W = SUM_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic idle_c;
    logic arm_c;
    logic beat_c;

    logic [SUM_W-1:0] sum_acc;
    logic [CNT_W-1:0] peak_acc;
    logic [WIN_W-1:0] ovf_acc;
    logic [WIN_W-1:0] bx_cnt;
    logic [WIN_W-1:0] win_len;

    logic [WIN_W-1:0] win_eff_c;
    logic [SXE_W-1:0] sum_ext_c;
    logic [SUM_W-1:0] sum_nxt_c;
    logic [CNT_W-1:0] peak_nxt_c;
    logic [WIN_W-1:0] ovf_nxt_c;
    logic [BXE_W-1:0] bx_nxt_c;
    logic             hit_c;
    logic             last_c;
    logic             slot_free_c;

    // State register
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping enable aborts from any state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable_i) state_nxt = ST_ARM;
            ST_ARM:   state_nxt = ST_ACCUM;
            ST_ACCUM: state_nxt = ST_ACCUM;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!enable_i) begin
            state_nxt = ST_IDLE;
        end
    end

    // State decode into datapath controls
    always_comb begin
        idle_c = 1'b0;
        arm_c  = 1'b0;
        beat_c = 1'b0;
        case (state)
            ST_IDLE:  idle_c = 1'b1;
            ST_ARM:   arm_c  = 1'b1;
            ST_ACCUM: beat_c = enable_i & cnt_valid_i;
            default:  idle_c = 1'b1;
        endcase
    end

    // Per-beat accumulator update candidates, all saturating
    always_comb begin
        win_eff_c   = (window_bx_i == '0) ? WIN_W'(1) : window_bx_i;
        hit_c       = (cnt_i > threshold_i);
        sum_ext_c   = SXE_W'(sum_acc) + SXE_W'(cnt_i);
        sum_nxt_c   = sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];
        peak_nxt_c  = (cnt_i > peak_acc) ? cnt_i : peak_acc;
        ovf_nxt_c   = (hit_c && (ovf_acc != '1)) ? ovf_acc + WIN_W'(1) : ovf_acc;
        bx_nxt_c    = BXE_W'(bx_cnt) + BXE_W'(1);
        last_c      = beat_c && (bx_nxt_c == BXE_W'(win_len));
        slot_free_c = !result_valid_o || result_ready_i;
    end

    // Window accumulators; a completing beat restarts the window with no gap
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            sum_acc  <= '0;
            peak_acc <= '0;
            ovf_acc  <= '0;
            bx_cnt   <= '0;
            win_len  <= '0;
        end else if (idle_c) begin
            sum_acc  <= '0;
            peak_acc <= '0;
            ovf_acc  <= '0;
            bx_cnt   <= '0;
        end else if (arm_c || last_c) begin
            sum_acc  <= '0;
            peak_acc <= '0;
            ovf_acc  <= '0;
            bx_cnt   <= '0;
            win_len  <= win_eff_c;
        end else if (beat_c) begin
            sum_acc  <= sum_nxt_c;
            peak_acc <= peak_nxt_c;
            ovf_acc  <= ovf_nxt_c;
            bx_cnt   <= bx_nxt_c[WIN_W-1:0];
        end
    end

    // Output slot: load wins over accept; data held after accept
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            result_valid_o <= 1'b0;
            sum_o          <= '0;
            peak_o         <= '0;
            ovf_bx_o       <= '0;
            nbx_o          <= '0;
        end else if (last_c && slot_free_c) begin
            result_valid_o <= 1'b1;
            sum_o          <= sum_nxt_c;
            peak_o         <= peak_nxt_c;
            ovf_bx_o       <= ovf_nxt_c;
            nbx_o          <= win_len;
        end else if (result_valid_o && result_ready_i) begin
            result_valid_o <= 1'b0;
        end
    end

    // Sticky drop flag, cleared when a fresh run arms
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            lost_o <= 1'b0;
        end else if (arm_c) begin
            lost_o <= 1'b0;
        end else if (last_c && !slot_free_c) begin
            lost_o <= 1'b1;
        end
    end

    // Per-BX overflow flag, independent of the window FSM
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            ovf_o <= 1'b0;
        end else begin
            ovf_o <= cnt_valid_i & hit_c;
        end
    end

endmodule

// File: tb/tb_cluster_rate_monitor.sv
// Directed bench for cluster_rate_monitor with hand-computed window results.
module tb_cluster_rate_monitor;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned WIN_W = 16;
    localparam int unsigned SUM_W = 27;
    localparam int unsigned SLOT_W = 1 + SUM_W + CNT_W + 2 * WIN_W;

    logic             clock4x = 1'b0;
    logic             reset_n;
    logic             enable_i;
    logic [CNT_W-1:0] cnt_i;
    logic             cnt_valid_i;
    logic [CNT_W-1:0] threshold_i;
    logic [WIN_W-1:0] window_bx_i;
    logic             ovf_o;
    logic             result_valid_o;
    logic             result_ready_i;
    logic [SUM_W-1:0] sum_o;
    logic [CNT_W-1:0] peak_o;
    logic [WIN_W-1:0] ovf_bx_o;
    logic [WIN_W-1:0] nbx_o;
    logic             lost_o;

    logic [SLOT_W-1:0] slot;
    assign slot = {result_valid_o, sum_o, peak_o, ovf_bx_o, nbx_o};

    int vec_cnt = 0;
    int err_cnt = 0;

    cluster_rate_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SUM_W(SUM_W)) dut (
        .clock4x        (clock4x),
        .reset_n        (reset_n),
        .enable_i       (enable_i),
        .cnt_i          (cnt_i),
        .cnt_valid_i    (cnt_valid_i),
        .threshold_i    (threshold_i),
        .window_bx_i    (window_bx_i),
        .ovf_o          (ovf_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .sum_o          (sum_o),
        .peak_o         (peak_o),
        .ovf_bx_o       (ovf_bx_o),
        .nbx_o          (nbx_o),
        .lost_o         (lost_o)
    );

    always #5 clock4x = ~clock4x;

    task automatic tick();
        @(posedge clock4x);
        #1;
    endtask

    task automatic beat(input int c);
        cnt_valid_i = 1'b1;
        cnt_i       = CNT_W'(c);
        tick();
    endtask

    task automatic quiet();
        cnt_valid_i = 1'b0;
        cnt_i       = '0;
    endtask

    // Drop enable for a cycle, then arm a fresh run with window w
    task automatic start_mon(input int w);
        quiet();
        enable_i = 1'b0;
        tick();
        window_bx_i = WIN_W'(w);
        enable_i    = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable_i = 1'b0; cnt_i = '0; cnt_valid_i = 1'b0;
        threshold_i = '0; window_bx_i = '0; result_ready_i = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if ({slot, lost_o, ovf_o} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs got %h exp 0", {slot, lost_o, ovf_o});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        threshold_i = 11'd8; result_ready_i = 1'b1;
        start_mon(4);
        beat(3);
        vec_cnt++;
        if (ovf_o !== 1'b0) begin err_cnt++; $display("FAIL basic_ovf0 got %b exp 0", ovf_o); end
        beat(9);
        vec_cnt++;
        if (ovf_o !== 1'b1) begin err_cnt++; $display("FAIL basic_ovf1 got %b exp 1", ovf_o); end
        beat(0);
        vec_cnt++;
        if ({ovf_o, result_valid_o} !== 2'b00) begin
            err_cnt++; $display("FAIL basic_ovf2_valid got %b exp 00", {ovf_o, result_valid_o});
        end
        beat(12);
        vec_cnt++;
        if (ovf_o !== 1'b1) begin err_cnt++; $display("FAIL basic_ovf3 got %b exp 1", ovf_o); end
        vec_cnt++;
        if (slot !== {1'b1, 27'd24, 11'd12, 16'd2, 16'd4}) begin
            err_cnt++; $display("FAIL basic_result got %h exp %h", slot, {1'b1, 27'd24, 11'd12, 16'd2, 16'd4});
        end
        quiet();
        tick();
        vec_cnt++;
        if (result_valid_o !== 1'b0) begin err_cnt++; $display("FAIL basic_accept got %b exp 0", result_valid_o); end
    endtask

    task automatic test_backpressure();
        threshold_i = 11'd100; result_ready_i = 1'b0;
        start_mon(2);
        beat(5); beat(6);
        vec_cnt++;
        if ({slot, lost_o} !== {1'b1, 27'd11, 11'd6, 16'd0, 16'd2, 1'b0}) begin
            err_cnt++; $display("FAIL bp_first got %h lost %b", slot, lost_o);
        end
        beat(1); beat(1);
        vec_cnt++;
        if ({slot, lost_o} !== {1'b1, 27'd11, 11'd6, 16'd0, 16'd2, 1'b1}) begin
            err_cnt++; $display("FAIL bp_second got %h lost %b exp lost 1", slot, lost_o);
        end
        beat(2); beat(2);
        quiet();
        tick();
        vec_cnt++;
        if ({slot, lost_o} !== {1'b1, 27'd11, 11'd6, 16'd0, 16'd2, 1'b1}) begin
            err_cnt++; $display("FAIL bp_third got %h lost %b", slot, lost_o);
        end
        result_ready_i = 1'b1;
        tick();
        vec_cnt++;
        if ({slot, lost_o} !== {1'b0, 27'd11, 11'd6, 16'd0, 16'd2, 1'b1}) begin
            err_cnt++; $display("FAIL bp_accept got %h lost %b exp valid 0 data held", slot, lost_o);
        end
    endtask

    task automatic test_back_to_back();
        threshold_i = 11'd100; result_ready_i = 1'b1;
        start_mon(2);
        vec_cnt++;
        if (lost_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_lost_clear got %b exp 0", lost_o); end
        for (int k = 1; k <= 8; k++) begin
            beat(k);
            if (k % 2 == 0) begin
                vec_cnt++;
                if (slot !== {1'b1, SUM_W'(2 * k - 1), CNT_W'(k), 16'd0, 16'd2}) begin
                    err_cnt++; $display("FAIL b2b_result k=%0d got %h exp sum %0d peak %0d", k, slot, 2 * k - 1, k);
                end
            end else if (k > 1) begin
                vec_cnt++;
                if (result_valid_o !== 1'b0) begin
                    err_cnt++; $display("FAIL b2b_gap k=%0d got %b exp 0", k, result_valid_o);
                end
            end
        end
        quiet();
        tick();
        vec_cnt++;
        if (lost_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_lost got %b exp 0", lost_o); end
    endtask

    task automatic test_long_window();
        threshold_i = 11'd0; result_ready_i = 1'b1;
        start_mon(65535);
        for (int i = 0; i < 65535; i++) begin
            beat(1536);
            if (i == 65533) begin
                vec_cnt++;
                if (result_valid_o !== 1'b0) begin
                    err_cnt++; $display("FAIL long_early got %b exp 0", result_valid_o);
                end
            end
        end
        vec_cnt++;
        if (slot !== {1'b1, 27'd100661760, 11'd1536, 16'd65535, 16'd65535}) begin
            err_cnt++; $display("FAIL long_result got %h exp %h", slot, {1'b1, 27'd100661760, 11'd1536, 16'd65535, 16'd65535});
        end
        quiet();
        tick();
    endtask

    task automatic test_enable_drop();
        threshold_i = 11'd100; result_ready_i = 1'b1;
        start_mon(5);
        beat(10); beat(10); beat(10);
        quiet();
        enable_i = 1'b0;
        tick();
        beat(200);
        vec_cnt++;
        if ({ovf_o, result_valid_o} !== 2'b10) begin
            err_cnt++; $display("FAIL idle_ovf_valid got %b exp 10", {ovf_o, result_valid_o});
        end
        quiet();
        tick();
        start_mon(5);
        for (int k = 1; k <= 5; k++) begin
            beat(k);
            if (k == 4) begin
                vec_cnt++;
                if (result_valid_o !== 1'b0) begin
                    err_cnt++; $display("FAIL rearm_early got %b exp 0", result_valid_o);
                end
            end
        end
        vec_cnt++;
        if (slot !== {1'b1, 27'd15, 11'd5, 16'd0, 16'd5}) begin
            err_cnt++; $display("FAIL rearm_result got %h exp %h", slot, {1'b1, 27'd15, 11'd5, 16'd0, 16'd5});
        end
        quiet();
        tick();
        // pending result plus a partial window, then an async reset pulse
        threshold_i = 11'd3; result_ready_i = 1'b0;
        start_mon(2);
        beat(7); beat(8); beat(9);
        quiet();
        vec_cnt++;
        if ({result_valid_o, ovf_o} !== 2'b11) begin
            err_cnt++; $display("FAIL prereset got %b exp 11", {result_valid_o, ovf_o});
        end
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if ({slot, lost_o, ovf_o} !== '0) begin
            err_cnt++; $display("FAIL async_reset got %h exp 0", {slot, lost_o, ovf_o});
        end
        #2;
        reset_n = 1'b1;
        result_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_window_zero();
        threshold_i = 11'd100; result_ready_i = 1'b1;
        start_mon(0);
        for (int k = 4; k <= 6; k++) begin
            beat(k);
            vec_cnt++;
            if (slot !== {1'b1, SUM_W'(k), CNT_W'(k), 16'd0, 16'd1}) begin
                err_cnt++; $display("FAIL win0 k=%0d got %h exp sum %0d nbx 1", k, slot, k);
            end
        end
        start_mon(4);
        beat(1); beat(1);
        window_bx_i = 16'd2;
        beat(1);
        vec_cnt++;
        if (result_valid_o !== 1'b0) begin err_cnt++; $display("FAIL winchg_early got %b exp 0", result_valid_o); end
        beat(1);
        vec_cnt++;
        if (slot !== {1'b1, 27'd4, 11'd1, 16'd0, 16'd4}) begin
            err_cnt++; $display("FAIL winchg_old got %h exp %h", slot, {1'b1, 27'd4, 11'd1, 16'd0, 16'd4});
        end
        beat(2);
        vec_cnt++;
        if (result_valid_o !== 1'b0) begin err_cnt++; $display("FAIL winchg_mid got %b exp 0", result_valid_o); end
        beat(2);
        vec_cnt++;
        if (slot !== {1'b1, 27'd4, 11'd2, 16'd0, 16'd2}) begin
            err_cnt++; $display("FAIL winchg_new got %h exp %h", slot, {1'b1, 27'd4, 11'd2, 16'd0, 16'd2});
        end
        quiet();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_long_window();
        test_enable_drop();
        test_window_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
